// File: rtl/axi_slice_pkg.sv
// Shared types for the AXI read responder slice.
// Response codes, burst encodings and FSM states.
package axi_slice_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ERR
  } state_e;

  localparam int unsigned FIFO_DEPTH = 2;

  function automatic logic burst_ok(logic [1:0] b);
    return (b == BURST_FIXED) || (b == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_r_resp_fifo.sv
// Two-entry response FIFO holding {data, err} per beat.
// Head is read straight from registered storage.
module axi_r_resp_fifo #(
  parameter int unsigned W = 65
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;
  logic         w_wr;
  logic         w_rd;

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rptr];

  // push on full is only taken together with a pop
  assign w_wr = i_push && (!o_full || i_pop);
  assign w_rd = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= !r_wptr;
      end
      if (w_rd) r_rptr <= !r_rptr;
      unique case (1'b1)
        (w_wr && !w_rd): r_cnt <= r_cnt + 2'd1;
        (w_rd && !w_wr): r_cnt <= r_cnt - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi_r_responder.sv
// AXI slave read responder: one AR at a time, split into
// per-beat memory requests, data returned as an R burst.
module axi_r_responder
  import axi_slice_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]            ar_len_i,
  input  logic [2:0]            ar_size_i,
  input  logic [1:0]            ar_burst_i,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [USER_WIDTH-1:0] ar_user_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [USER_WIDTH-1:0] r_user_o,
  output logic                  r_last_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i
);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_issue_cnt;
  logic [7:0]            r_out_cnt;
  logic [2:0]            r_size;
  logic                  r_fixed;
  logic [ID_WIDTH-1:0]   r_id;
  logic [USER_WIDTH-1:0] r_user;
  logic [1:0]            r_pend;

  logic [DATA_WIDTH:0]   w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [1:0]            w_cnt;
  logic [2:0]            w_credits;
  logic                  w_gnt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rhs;
  logic                  w_err_st;
  logic                  w_data_st;
  logic                  w_head_vld;
  logic [ADDR_WIDTH-1:0] w_step;

  axi_r_resp_fifo #(
    .W(DATA_WIDTH + 1)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_push),
    .i_data  ({mem_rdata_i, mem_err_i}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  // credits cover beats in flight plus beats parked in the FIFO
  assign w_credits  = {1'b0, r_pend} + {1'b0, w_cnt};
  assign w_err_st   = (r_state == ST_ERR);
  assign w_data_st  = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign w_head_vld = w_data_st && !w_empty;
  assign w_step     = ADDR_WIDTH'(1) << r_size;

  assign ar_ready_o = (r_state == ST_IDLE);
  assign mem_req_o  = (r_state == ST_ISSUE) && !w_full
                   && (w_credits < 3'd2);
  assign mem_addr_o = r_addr;

  assign w_gnt  = mem_req_o && mem_gnt_i;
  assign w_push = mem_rvalid_i && (r_pend != 2'd0);

  assign r_valid_o = w_err_st || w_head_vld;
  assign r_data_o  = w_head_vld ? w_head[DATA_WIDTH:1] : '0;
  assign r_resp_o  = (w_err_st || (w_head_vld && w_head[0]))
                   ? RESP_SLVERR : RESP_OKAY;
  assign r_last_o  = r_valid_o && (r_out_cnt == r_len);
  assign r_id_o    = r_id;
  assign r_user_o  = r_user;

  assign w_rhs = r_valid_o && r_ready_i;
  assign w_pop = w_rhs && w_data_st;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= 2'd0;
    end else begin
      unique case (1'b1)
        (w_gnt && !w_push): r_pend <= r_pend + 2'd1;
        (w_push && !w_gnt): r_pend <= r_pend - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_len       <= 8'd0;
      r_issue_cnt <= 8'd0;
      r_out_cnt   <= 8'd0;
      r_size      <= 3'd0;
      r_fixed     <= 1'b0;
      r_id        <= '0;
      r_user      <= '0;
    end else begin
      if (w_rhs) r_out_cnt <= r_out_cnt + 8'd1;
      unique case (r_state)
        ST_IDLE: begin
          if (ar_valid_i) begin
            r_addr      <= ar_addr_i;
            r_len       <= ar_len_i;
            r_size      <= ar_size_i;
            r_fixed     <= (ar_burst_i == BURST_FIXED);
            r_id        <= ar_id_i;
            r_user      <= ar_user_i;
            r_issue_cnt <= 8'd0;
            r_out_cnt   <= 8'd0;
            r_state     <= burst_ok(ar_burst_i) ? ST_ISSUE : ST_ERR;
          end
        end
        ST_ISSUE: begin
          if (w_gnt) begin
            if (!r_fixed) r_addr <= r_addr + w_step;
            if (r_issue_cnt == r_len) r_state <= ST_WAIT;
            else r_issue_cnt <= r_issue_cnt + 8'd1;
          end
        end
        ST_WAIT, ST_ERR: begin
          if (w_rhs && r_last_o) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_r_responder.sv
// Directed bench for axi_r_responder with a
// one-cycle-latency memory model and an R beat collector.
module tb_axi_r_responder;

  logic        clk;
  logic        rst_ni;
  logic        ar_valid_i;
  logic        ar_ready_o;
  logic [31:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic [2:0]  ar_size_i;
  logic [1:0]  ar_burst_i;
  logic [3:0]  ar_id_i;
  logic [5:0]  ar_user_i;
  logic        r_valid_o;
  logic        r_ready_i;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic [3:0]  r_id_o;
  logic [5:0]  r_user_o;
  logic        r_last_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        mem_err_i;

  axi_r_responder dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .ar_valid_i   (ar_valid_i),
    .ar_ready_o   (ar_ready_o),
    .ar_addr_i    (ar_addr_i),
    .ar_len_i     (ar_len_i),
    .ar_size_i    (ar_size_i),
    .ar_burst_i   (ar_burst_i),
    .ar_id_i      (ar_id_i),
    .ar_user_i    (ar_user_i),
    .r_valid_o    (r_valid_o),
    .r_ready_i    (r_ready_i),
    .r_data_o     (r_data_o),
    .r_resp_o     (r_resp_o),
    .r_id_o       (r_id_o),
    .r_user_o     (r_user_o),
    .r_last_o     (r_last_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic [5:0]  user;
    logic        last;
  } beat_t;

  beat_t       bq[$];
  logic [31:0] gq[$];
  int          err_idx = -1;
  int          rcnt = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        pv;
  logic [31:0] pa;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mdata(logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory: grants every request, data one cycle later
  initial begin
    pv = 1'b0;
    pa = '0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    mem_err_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        pv = 1'b0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_err_i = 1'b0;
      end else begin
        mem_rvalid_i = pv;
        mem_rdata_i = pv ? mdata(pa) : '0;
        mem_err_i = pv && (rcnt == err_idx);
        if (pv) rcnt++;
        pv = 1'b0;
        mem_gnt_i = mem_req_o;
        if (mem_req_o) begin
          pv = 1'b1;
          pa = mem_addr_o;
          gq.push_back(mem_addr_o);
        end
      end
    end
  end

  initial begin : collect
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_ni && r_valid_o && r_ready_i) begin
        b.d = r_data_o;
        b.resp = r_resp_o;
        b.id = r_id_o;
        b.user = r_user_o;
        b.last = r_last_o;
        bq.push_back(b);
      end
    end
  end

  task automatic clear();
    gq.delete();
    bq.delete();
    rcnt = 0;
    err_idx = -1;
  endtask

  task automatic send_ar(logic [31:0] a, logic [7:0] l, logic [2:0] s,
                         logic [1:0] bu, logic [3:0] id, logic [5:0] u);
    int k;
    k = 0;
    @(negedge clk);
    while (!ar_ready_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ar_ready", 64'(ar_ready_o), 64'd1);
    ar_addr_i = a;
    ar_len_i = l;
    ar_size_i = s;
    ar_burst_i = bu;
    ar_id_i = id;
    ar_user_i = u;
    ar_valid_i = 1'b1;
    @(negedge clk);
    ar_valid_i = 1'b0;
  endtask

  task automatic wait_beats(int n);
    int k;
    k = 0;
    while (bq.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_burst(string t, int n, logic [31:0] base,
                             logic [31:0] stride, int err_i,
                             logic [3:0] id, logic [5:0] u);
    logic [31:0] a;
    repeat (4) @(negedge clk);
    chk({t, "_ngnt"}, 64'(gq.size()), 64'(n));
    chk({t, "_nbeat"}, 64'(bq.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      a = base + 32'(i) * stride;
      if (i < gq.size()) chk({t, "_addr"}, 64'(gq[i]), 64'(a));
      if (i < bq.size()) begin
        chk({t, "_data"}, bq[i].d, mdata(a));
        chk({t, "_resp"}, 64'(bq[i].resp),
            64'((i == err_i) ? 2'b10 : 2'b00));
        chk({t, "_last"}, 64'(bq[i].last), 64'(i == n - 1));
        chk({t, "_id"}, 64'(bq[i].id), 64'(id));
        chk({t, "_user"}, 64'(bq[i].user), 64'(u));
      end
    end
  endtask

  task automatic chk_reset_outs(string t);
    chk({t, "_arrdy"}, 64'(ar_ready_o), 64'd1);
    chk({t, "_rvld"}, 64'(r_valid_o), 64'd0);
    chk({t, "_req"}, 64'(mem_req_o), 64'd0);
    chk({t, "_rdata"}, r_data_o, 64'd0);
    chk({t, "_rresp"}, 64'(r_resp_o), 64'd0);
    chk({t, "_rlast"}, 64'(r_last_o), 64'd0);
    chk({t, "_rid"}, 64'(r_id_o), 64'd0);
    chk({t, "_maddr"}, 64'(mem_addr_o), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    ar_valid_i = 1'b0;
    ar_addr_i = '0;
    ar_len_i = '0;
    ar_size_i = '0;
    ar_burst_i = '0;
    ar_id_i = '0;
    ar_user_i = '0;
    r_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rst_ni = 1'b1;

    // 1: INCR, 4 beats of 8 bytes
    clear();
    send_ar(32'h100, 8'd3, 3'd3, 2'b01, 4'h5, 6'h2A);
    chk("t1_arrdy_busy", 64'(ar_ready_o), 64'd0);
    wait_beats(4);
    check_burst("t1", 4, 32'h100, 32'd8, -1, 4'h5, 6'h2A);

    // 2: FIXED, all requests to one address
    clear();
    send_ar(32'h40, 8'd2, 3'd3, 2'b00, 4'h9, 6'h11);
    wait_beats(3);
    check_burst("t2", 3, 32'h40, 32'd0, -1, 4'h9, 6'h11);

    // 3: unsupported burst, SLVERR beats without memory access
    clear();
    send_ar(32'h500, 8'd1, 3'd3, 2'b10, 4'hC, 6'h3F);
    wait_beats(2);
    repeat (4) @(negedge clk);
    chk("t3_ngnt", 64'(gq.size()), 64'd0);
    chk("t3_nbeat", 64'(bq.size()), 64'd2);
    for (int i = 0; i < 2; i++) begin
      if (i < bq.size()) begin
        chk("t3_data", bq[i].d, 64'd0);
        chk("t3_resp", 64'(bq[i].resp), 64'd2);
        chk("t3_last", 64'(bq[i].last), 64'(i == 1));
        chk("t3_id", 64'(bq[i].id), 64'hC);
      end
    end

    // 4: back-pressure limits issue to two credits
    clear();
    @(posedge clk);
    #1;
    r_ready_i = 1'b0;
    send_ar(32'h200, 8'd7, 3'd3, 2'b01, 4'h1, 6'h03);
    repeat (20) @(negedge clk);
    chk("t4_ngnt_stall", 64'(gq.size()), 64'd2);
    chk("t4_req_stall", 64'(mem_req_o), 64'd0);
    chk("t4_rvld_stall", 64'(r_valid_o), 64'd1);
    chk("t4_rdata_stall", r_data_o, mdata(32'h200));
    chk("t4_arrdy_stall", 64'(ar_ready_o), 64'd0);
    @(posedge clk);
    #1;
    r_ready_i = 1'b1;
    wait_beats(8);
    check_burst("t4", 8, 32'h200, 32'd8, -1, 4'h1, 6'h03);

    // 5: memory error on the second beat only
    clear();
    err_idx = 1;
    send_ar(32'h300, 8'd3, 3'd2, 2'b01, 4'h6, 6'h15);
    wait_beats(4);
    check_burst("t5", 4, 32'h300, 32'd4, 1, 4'h6, 6'h15);

    // 6: reset mid-burst, then a single-beat command
    clear();
    send_ar(32'h400, 8'd7, 3'd3, 2'b01, 4'h7, 6'h05);
    wait_beats(2);
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    #2;
    chk_reset_outs("t6_rst");
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    clear();
    send_ar(32'h80, 8'd0, 3'd3, 2'b01, 4'h3, 6'h01);
    wait_beats(1);
    check_burst("t6", 1, 32'h80, 32'd8, -1, 4'h3, 6'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
